// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared state encoding and counter width helper for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: PLL-side and core-reset-side signals of the lock supervisor.
// Build macro PLL_SUPERVISOR_LOSS_CNT_EN adds the loss_cnt status field.
interface pll_lock_supervisor_if #(
    parameter int MAX_RETRIES = 4
);
    import pll_sup_pkg::*;

    localparam int RC_W = cnt_w(MAX_RETRIES);

    logic            pll_locked;
    logic            pll_rst;
    logic            sys_reset;
    logic            lock_lost;
    logic            fail;
    logic [RC_W-1:0] retry_cnt;
    state_t          state_o;
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    logic [7:0]      loss_cnt;

    modport master (
        input  pll_locked,
        output pll_rst, sys_reset, lock_lost, fail, retry_cnt, state_o, loss_cnt
    );
    modport slave (
        output pll_locked,
        input  pll_rst, sys_reset, lock_lost, fail, retry_cnt, state_o, loss_cnt
    );
`else
    modport master (
        input  pll_locked,
        output pll_rst, sys_reset, lock_lost, fail, retry_cnt, state_o
    );
    modport slave (
        output pll_locked,
        input  pll_rst, sys_reset, lock_lost, fail, retry_cnt, state_o
    );
`endif

endinterface

// File: rtl/pll_sup_sync.sv
// pll_sup_sync: STAGES-deep single-bit synchronizer with async active-low clear.
// The first flop samples an asynchronous input; timing to it is a false path.
module pll_sup_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    (* async_reg = "true", false_path = "true" *) logic first_q;
    (* async_reg = "true" *) logic [STAGES-2:0] rest_q;

    // Shift the asynchronous input through the chain, cleared on reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            first_q <= 1'b0;
            rest_q  <= '0;
        end else begin
            first_q   <= d_i;
            rest_q[0] <= first_q;
            for (int i = 1; i < STAGES - 1; i++) begin
                rest_q[i] <= rest_q[i-1];
            end
        end
    end

    assign q_o = rest_q[STAGES-2];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: pulses the PLL reset, waits for lock with timeout/retry, qualifies
// lock stability and only then releases the core reset. Runs entirely on refclk.
// Build macro PLL_SUPERVISOR_LOSS_CNT_EN adds an 8-bit saturating lock-loss counter.
//
// state      | meaning
// RESET_PLL  | pll_rst held high for RST_PULSE cycles
// WAIT_LOCK  | pll_rst low, waiting for locked_s, retry after LOCK_TIMEOUT cycles
// STABILIZE  | counting consecutive locked_s cycles up to STABLE_CYCLES
// RUN        | lock qualified, sys_reset released
// FAIL       | MAX_RETRIES consecutive timeouts, PLL held in reset until rst_n
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE     = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_lock_supervisor_if.master pll_if
);

    // One phase counter serves the reset pulse, the lock timeout and the stability count,
    // since only one of them is active in any state; it is cleared on every transition.
    localparam int CNT_AB  = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
    localparam int CNT_MAX = (CNT_AB > STABLE_CYCLES) ? CNT_AB : STABLE_CYCLES;
    localparam int CNT_W   = cnt_w(CNT_MAX);
    localparam int RC_W    = cnt_w(MAX_RETRIES);

    localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [RC_W-1:0]  retry_q, retry_d, retry_inc;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_reset_q, sys_reset_d;
    logic             lock_lost_q, lock_lost_d;
    logic             fail_q, fail_d;
    logic             locked_s;

    pll_sup_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i   (refclk),
        .rst_n_i (rst_n),
        .d_i     (pll_if.pll_locked),
        .q_o     (locked_s)
    );

    assign cnt_inc   = (cnt_q == CNT_LIM) ? cnt_q : cnt_q + CNT_W'(1);
    assign retry_inc = (retry_q == RC_MAX) ? retry_q : retry_q + RC_W'(1);

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;
        unique case (state_q)
            RESET_PLL: begin
                if (cnt_q >= RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q >= TMO_LAST) begin
                    cnt_d   = '0;
                    retry_d = retry_inc;
                    state_d = (retry_inc == RC_MAX) ? FAIL : RESET_PLL;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q >= STB_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d     = RESET_PLL;
                    cnt_d       = '0;
                    lock_lost_d = 1'b1;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase
        pll_rst_d   = (state_d == RESET_PLL) || (state_d == FAIL);
        sys_reset_d = (state_d != RUN);
        fail_d      = (state_d == FAIL);
    end

    // State and outputs registered together so sys_reset only deasserts on a refclk edge.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            lock_lost_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            lock_lost_q <= lock_lost_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_if.pll_rst   = pll_rst_q;
    assign pll_if.sys_reset = sys_reset_q;
    assign pll_if.lock_lost = lock_lost_q;
    assign pll_if.fail      = fail_q;
    assign pll_if.retry_cnt = retry_q;
    assign pll_if.state_o   = state_q;

`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    // Count lock losses in step with the lock_lost pulse, holding at 255.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lock_lost_d && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    // Loss counter register, cleared only by rst_n.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= 8'd0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign pll_if.loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed scenarios; expected output changes are queued with the
// number of cycles since the previous change and checked by an edge-driven monitor.
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_bad   = 0;
    bit   mon_en  = 1'b1;

    typedef struct {
        int          delta;
        logic [10:0] snap;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    pll_lock_supervisor_if #(.MAX_RETRIES(2)) bus ();

    pll_lock_supervisor #(
        .RST_PULSE     (4),
        .LOCK_TIMEOUT  (100),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2),
        .SYNC_STAGES   (2)
    ) dut (
        .refclk (clk),
        .rst_n  (rst_n),
        .pll_if (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] mk(input logic r, input logic l, input state_t s,
                                       input logic pr, input logic sr, input logic ll,
                                       input logic f, input logic [1:0] rc);
        return {r, l, s, pr, sr, ll, f, rc};
    endfunction

    function automatic logic [10:0] snap_now();
        return {rst_n, bus.pll_locked, bus.state_o, bus.pll_rst, bus.sys_reset,
                bus.lock_lost, bus.fail, bus.retry_cnt};
    endfunction

    task automatic push(input int d, input logic [10:0] s, input string nm);
        exp_t e;
        e.delta = d;
        e.snap  = s;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Lock lost in RUN: pulse, pulse end, then pll_rst falls after 4 cycles.
    task automatic push_loss(input int d_drop);
        push(d_drop, mk(1, 0, RUN, 0, 0, 0, 0, 0), "lock_drop");
        push(3, mk(1, 0, RESET_PLL, 1, 1, 1, 0, 0), "lock_lost_pulse");
        push(1, mk(1, 0, RESET_PLL, 1, 1, 0, 0, 0), "lock_lost_end");
        push(3, mk(1, 0, WAIT_LOCK, 0, 1, 0, 0, 0), "pll_rst_fall");
    endtask

    // Monitor: every change of the observed vector pops one expectation.
    int          ncnt = 0;
    int          last = 0;
    logic [10:0] prev = 11'b0_0_000_1_1_0_0_00;
    logic [10:0] cur;
    exp_t        it;

    always @(negedge clk) begin
        ncnt++;
        cur = snap_now();
        if (cur !== prev) begin
            if (mon_en) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: got %03h after %0d cycles, want no change",
                             cur, ncnt - last);
                end else begin
                    it = exp_q.pop_front();
                    if ((it.snap !== cur) || (it.delta != ncnt - last)) begin
                        n_bad++;
                        $display("FAIL %s: got %03h after %0d cycles, want %03h after %0d cycles",
                                 it.name, cur, ncnt - last, it.snap, it.delta);
                    end
                end
            end
            last = ncnt;
            prev = cur;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    task automatic wait_state(input state_t s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.state_o == s) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask
`endif

    initial begin
        rst_n          = 1'b0;
        bus.pll_locked = 1'b0;
        @(posedge clk);
        #1;
        check("reset_state", 32'(snap_now()), 32'(mk(0, 0, RESET_PLL, 1, 1, 0, 0, 0)));
        step(2);

        // Basic bring-up: 4-cycle pll_rst, lock 10 cycles later, release 11 cycles after lock.
        push(3, mk(1, 0, RESET_PLL, 1, 1, 0, 0, 0), "rst_release");
        push(4, mk(1, 0, WAIT_LOCK, 0, 1, 0, 0, 0), "first_pll_rst_fall");
        push(10, mk(1, 1, WAIT_LOCK, 0, 1, 0, 0, 0), "first_lock");
        push(3, mk(1, 1, STABILIZE, 0, 1, 0, 0, 0), "first_stabilize");
        push(8, mk(1, 1, RUN, 0, 0, 0, 0, 0), "first_release");
        rst_n = 1'b1;
        step(14);
        bus.pll_locked = 1'b1;

        // Loss of lock in RUN and re-lock without counting a retry.
        push_loss(5);
        push(3, mk(1, 1, WAIT_LOCK, 0, 1, 0, 0, 0), "relock");
        push(3, mk(1, 1, STABILIZE, 0, 1, 0, 0, 0), "relock_stabilize");
        push(8, mk(1, 1, RUN, 0, 0, 0, 0, 0), "relock_release");
        step(16);
        bus.pll_locked = 1'b0;
        step(10);
        bus.pll_locked = 1'b1;

        // One-cycle glitch at stable count 5 forces 8 fresh stable cycles.
        push_loss(4);
        push(2, mk(1, 1, WAIT_LOCK, 0, 1, 0, 0, 0), "g_relock");
        push(3, mk(1, 1, STABILIZE, 0, 1, 0, 0, 0), "g_stabilize");
        push(3, mk(1, 0, STABILIZE, 0, 1, 0, 0, 0), "glitch_low");
        push(1, mk(1, 1, STABILIZE, 0, 1, 0, 0, 0), "glitch_high");
        push(2, mk(1, 1, WAIT_LOCK, 0, 1, 0, 0, 0), "glitch_back_to_wait");
        push(1, mk(1, 1, STABILIZE, 0, 1, 0, 0, 0), "glitch_restabilize");
        push(8, mk(1, 1, RUN, 0, 0, 0, 0, 0), "glitch_release");
        step(15);
        bus.pll_locked = 1'b0;
        step(9);
        bus.pll_locked = 1'b1;
        step(6);
        bus.pll_locked = 1'b0;
        step(1);
        bus.pll_locked = 1'b1;

        // One timeout, then rst_n asserted in STABILIZE with retry_cnt=1.
        push_loss(2);
        push(100, mk(1, 0, RESET_PLL, 1, 1, 0, 0, 1), "timeout_retry1");
        push(4, mk(1, 0, WAIT_LOCK, 0, 1, 0, 0, 1), "retry1_wait");
        push(1, mk(1, 1, WAIT_LOCK, 0, 1, 0, 0, 1), "retry1_lock");
        push(3, mk(1, 1, STABILIZE, 0, 1, 0, 0, 1), "retry1_stabilize");
        push(2, mk(0, 1, RESET_PLL, 1, 1, 0, 0, 0), "midseq_reset");
        push(3, mk(1, 1, RESET_PLL, 1, 1, 0, 0, 0), "midseq_release");
        push(4, mk(1, 1, WAIT_LOCK, 0, 1, 0, 0, 0), "restart_wait");
        push(1, mk(1, 1, STABILIZE, 0, 1, 0, 0, 0), "restart_stabilize");
        push(8, mk(1, 1, RUN, 0, 0, 0, 0, 0), "restart_release");
        step(13);
        bus.pll_locked = 1'b0;
        step(112);
        bus.pll_locked = 1'b1;
        step(5);
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
        check("loss_cnt_3", 32'(bus.loss_cnt), 32'd3);
`endif
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;

        // Two consecutive timeouts lead to sticky FAIL, immune to a later lock.
        push_loss(2);
        push(100, mk(1, 0, RESET_PLL, 1, 1, 0, 0, 1), "fail_path_retry1");
        push(4, mk(1, 0, WAIT_LOCK, 0, 1, 0, 0, 1), "fail_path_wait2");
        push(100, mk(1, 0, FAIL, 1, 1, 0, 1, 2), "enter_fail");
        push(10, mk(1, 1, FAIL, 1, 1, 0, 1, 2), "fail_lock_ignored");
        step(15);
        bus.pll_locked = 1'b0;
        step(221);
        bus.pll_locked = 1'b1;
        step(40);

        check("all_expected_seen", 32'(exp_q.size()), 32'd0);
        check("fail_sticky", 32'(snap_now()), 32'(mk(1, 1, FAIL, 1, 1, 0, 1, 2)));

`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
        begin
            bit ok;
            mon_en = 1'b0;
            rst_n  = 1'b0;
            step(2);
            rst_n = 1'b1;
            for (int i = 0; i < 300; i++) begin
                bus.pll_locked = 1'b1;
                wait_state(RUN, 40, ok);
                if (!ok) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL loss_loop_run: got no RUN within 40 cycles, want RUN (iter %0d)", i);
                    break;
                end
                bus.pll_locked = 1'b0;
                wait_state(RESET_PLL, 10, ok);
                if (!ok) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL loss_loop_drop: got no RESET_PLL within 10 cycles, want RESET_PLL (iter %0d)", i);
                    break;
                end
            end
            step(2);
            check("loss_cnt_sat", 32'(bus.loss_cnt), 32'd255);
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
